conv_window_3x3: RTL

CONV_WINDOW_3X3 -- requirements
Module: conv_window_3x3

---
 rtl/conv_window_3x3.sv | 115 +++++++++++
 1 files changed

// File: rtl/conv_window_3x3.sv
// rtl/conv_window_3x3.sv - 3x3 sliding pixel window over a raster stream using two line buffers.
// Window is registered; win_valid/frame_done pulse one cycle after the pixel that completes a window.
module conv_window_3x3 #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       pix_valid,
   input  logic       pix_sof,
   input  logic [8:0] pix_data,
   output logic [8:0] win_1,
   output logic [8:0] win_2,
   output logic [8:0] win_3,
   output logic [8:0] win_4,
   output logic [8:0] win_5,
   output logic [8:0] win_6,
   output logic [8:0] win_7,
   output logic [8:0] win_8,
   output logic [8:0] win_9,
   output logic       win_valid,
   output logic       frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0] col_q, col_d, pos_col;
   logic [RW-1:0] row_q, row_d, pos_row;
   logic          win_valid_q, win_valid_d;
   logic          frame_done_q, frame_done_d;
   logic [8:0]    win_q [3][3];
   logic [8:0]    win_d [3][3];
   logic [8:0]    lb1_q [IMG_W];
   logic [8:0]    lb2_q [IMG_W];

   // pix_sof forces this pixel to (0,0), overriding any pending wrap
   always_comb begin
      pos_col      = pix_sof ? '0 : col_q;
      pos_row      = pix_sof ? '0 : row_q;
      col_d        = col_q;
      row_d        = row_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      if (pix_valid) begin
         win_valid_d  = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
         frame_done_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
         if (pos_col == COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_ONE;
         end else begin
            col_d = pos_col + COL_ONE;
            row_d = pos_row;
         end
      end
   end

   always_comb begin
      win_d = win_q;
      if (pix_valid) begin
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = lb2_q[pos_col];
         win_d[1][2] = lb1_q[pos_col];
         win_d[2][2] = pix_data;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win_q[i][j] <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         win_q        <= win_d;
      end
   end

   // Line buffers are plain RAM; stale rows never reach a valid window since row_cnt restarts at 0
   always_ff @(posedge sys_clk) begin
      if (pix_valid) begin
         lb2_q[pos_col] <= lb1_q[pos_col];
         lb1_q[pos_col] <= pix_data;
      end
   end

   assign win_1      = win_q[0][0];
   assign win_2      = win_q[0][1];
   assign win_3      = win_q[0][2];
   assign win_4      = win_q[1][0];
   assign win_5      = win_q[1][1];
   assign win_6      = win_q[1][2];
   assign win_7      = win_q[2][0];
   assign win_8      = win_q[2][1];
   assign win_9      = win_q[2][2];
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule
